data_bus_responder: RTL and testbench

- Responder side of the core's data-memory interface. Consumes the core's `address`, `write_data` and `write_data_sig`, and returns `read_data` combinationally in the same cycle, as a single-cycle core requires.
- Decodes the address into three regions: a word-addressed RAM, a memory-mapped timer/control register window, and unmapped space.
- Drives the core's `external_interrupts` vector from a 64-bit machine timer and a software-interrupt bit.

---
 rtl/data_bus_responder.sv | 138 +++++++++++++
 tb/tb_data_bus_responder.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_bus_responder.sv
// rtl/data_bus_responder.sv - data-memory responder: word RAM, machine timer/GPIO/MSIP window, interrupts
module data_bus_responder #(
    parameter int          RAM_WORDS = 1024,
    parameter logic [31:0] RAM_BASE  = 32'h0001_0000,
    parameter logic [31:0] MMIO_BASE = 32'h1000_0000,
    parameter int          TICK_DIV  = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    input  logic        write_data_sig,
    output logic [31:0] read_data,
    output logic [31:0] external_interrupts,
    output logic [31:0] gpio_out
);

    localparam int AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

    // Byte lanes are ignored: every access is a whole word.
    logic unused_addr_bits;
    assign unused_addr_bits = ^address[1:0];

    // Address decode on word addresses so the region bounds need no 33-bit math.
    logic [29:0]   ram_woff;
    logic [29:0]   mmio_woff;
    logic          ram_hit;
    logic          mmio_hit;
    logic [AW-1:0] ram_idx;
    logic [2:0]    reg_sel;

    assign ram_woff  = address[31:2] - RAM_BASE[31:2];
    assign mmio_woff = address[31:2] - MMIO_BASE[31:2];
    assign ram_hit   = (address[31:2] >= RAM_BASE[31:2]) && (ram_woff[29:AW] == '0);
    assign mmio_hit  = (address[31:2] >= MMIO_BASE[31:2]) && (mmio_woff[29:3] == '0);
    assign ram_idx   = ram_woff[AW-1:0];
    assign reg_sel   = mmio_woff[2:0];

    logic [31:0] ram_q [RAM_WORDS];

    logic [PW-1:0] presc_q, presc_d;
    logic [31:0]   mtime_lo_q, mtime_lo_d;
    logic [31:0]   mtime_hi_q, mtime_hi_d;
    logic [31:0]   cmp_lo_q, cmp_lo_d;
    logic [31:0]   cmp_hi_q, cmp_hi_d;
    logic [31:0]   gpio_q, gpio_d;
    logic          msip_q, msip_d;
    logic [15:0]   bad_cnt_q, bad_cnt_d;
    logic          tirq_q, tirq_d;

    logic wr_mmio, wr_lo, wr_hi, tick;

    assign wr_mmio = write_data_sig && mmio_hit;
    assign wr_lo   = wr_mmio && (reg_sel == 3'd0);
    assign wr_hi   = wr_mmio && (reg_sel == 3'd1);
    assign tick    = (presc_q == TICK_LAST);

    // RAM store; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (write_data_sig && ram_hit) begin
            ram_q[ram_idx] <= write_data;
        end
    end

    // Next-state for timer, registers and the unmapped-write counter.
    always_comb begin
        presc_d    = tick ? '0 : presc_q + 1'b1;
        mtime_lo_d = mtime_lo_q;
        mtime_hi_d = mtime_hi_q;
        // A write to either mtime half freezes the counter for that cycle, so no carry leaks.
        if (wr_lo || wr_hi) begin
            if (wr_lo) mtime_lo_d = write_data;
            if (wr_hi) mtime_hi_d = write_data;
        end else if (tick) begin
            mtime_lo_d = mtime_lo_q + 32'd1;
            if (mtime_lo_q == 32'hFFFF_FFFF) mtime_hi_d = mtime_hi_q + 32'd1;
        end
        cmp_lo_d  = (wr_mmio && reg_sel == 3'd2) ? write_data : cmp_lo_q;
        cmp_hi_d  = (wr_mmio && reg_sel == 3'd3) ? write_data : cmp_hi_q;
        gpio_d    = (wr_mmio && reg_sel == 3'd4) ? write_data : gpio_q;
        msip_d    = (wr_mmio && reg_sel == 3'd5) ? write_data[0] : msip_q;
        bad_cnt_d = bad_cnt_q;
        if (write_data_sig && !ram_hit && !mmio_hit && bad_cnt_q != 16'hFFFF) begin
            bad_cnt_d = bad_cnt_q + 16'd1;
        end
        tirq_d = {mtime_hi_q, mtime_lo_q} >= {cmp_hi_q, cmp_lo_q};
    end

    // Register update; reset overrides any same-cycle write.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q    <= '0;
            mtime_lo_q <= '0;
            mtime_hi_q <= '0;
            cmp_lo_q   <= 32'hFFFF_FFFF;
            cmp_hi_q   <= 32'hFFFF_FFFF;
            gpio_q     <= '0;
            msip_q     <= 1'b0;
            bad_cnt_q  <= '0;
            tirq_q     <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            mtime_lo_q <= mtime_lo_d;
            mtime_hi_q <= mtime_hi_d;
            cmp_lo_q   <= cmp_lo_d;
            cmp_hi_q   <= cmp_hi_d;
            gpio_q     <= gpio_d;
            msip_q     <= msip_d;
            bad_cnt_q  <= bad_cnt_d;
            tirq_q     <= tirq_d;
        end
    end

    // Combinational read path, as the single-cycle core needs the data in the same cycle.
    always_comb begin
        read_data = '0;
        if (ram_hit) begin
            read_data = ram_q[ram_idx];
        end else if (mmio_hit) begin
            case (reg_sel)
                3'd0:    read_data = mtime_lo_q;
                3'd1:    read_data = mtime_hi_q;
                3'd2:    read_data = cmp_lo_q;
                3'd3:    read_data = cmp_hi_q;
                3'd4:    read_data = gpio_q;
                3'd5:    read_data = {31'd0, msip_q};
                3'd6:    read_data = {16'd0, bad_cnt_q};
                default: read_data = '0;
            endcase
        end
    end

    assign external_interrupts = {24'd0, tirq_q, 3'd0, msip_q, 3'd0};
    assign gpio_out            = gpio_q;

endmodule

// File: tb/tb_data_bus_responder.sv
// tb/tb_data_bus_responder.sv - scoreboard bench for data_bus_responder
module tb_data_bus_responder;

    localparam logic [31:0] RB  = 32'h0001_0000;
    localparam logic [31:0] MB  = 32'h1000_0000;
    localparam logic [31:0] UNM = 32'h2000_0000;
    localparam int          RW  = 1024;

    logic        clk;
    logic        rst;
    logic [31:0] address;
    logic [31:0] write_data;
    logic        write_data_sig;
    logic [31:0] read_data;
    logic [31:0] external_interrupts;
    logic [31:0] gpio_out;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] exp_q[$];
    string       tag_q[$];

    data_bus_responder #(
        .RAM_WORDS(RW),
        .RAM_BASE (RB),
        .MMIO_BASE(MB),
        .TICK_DIV (1)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .address            (address),
        .write_data         (write_data),
        .write_data_sig     (write_data_sig),
        .read_data          (read_data),
        .external_interrupts(external_interrupts),
        .gpio_out           (gpio_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [31:0] exp);
        tag_q.push_back(tag);
        exp_q.push_back(exp);
    endtask

    task automatic sb_pop(input logic [31:0] obs);
        string       t;
        logic [31:0] e;
        t = tag_q.pop_front();
        e = exp_q.pop_front();
        check_eq(t, obs, e);
    endtask

    task automatic write_word(input logic [31:0] a, input logic [31:0] d);
        address        = a;
        write_data     = d;
        write_data_sig = 1'b1;
        @(negedge clk);
        write_data_sig = 1'b0;
    endtask

    task automatic idle(input int n);
        write_data_sig = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic read_check(input string tag, input logic [31:0] a, input logic [31:0] exp);
        address        = a;
        write_data_sig = 1'b0;
        sb_push(tag, exp);
        #1;
        sb_pop(read_data);
    endtask

    task automatic irq_check(input string tag, input logic [31:0] exp);
        sb_push(tag, exp);
        #1;
        sb_pop(external_interrupts);
    endtask

    task automatic gpio_check(input string tag, input logic [31:0] exp);
        sb_push(tag, exp);
        #1;
        sb_pop(gpio_out);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst            = 1'b1;
        address        = '0;
        write_data     = '0;
        write_data_sig = 1'b0;

        // Reset state, read during reset
        @(negedge clk);
        read_check("rst_cmp_lo", MB + 32'h08, 32'hFFFF_FFFF);
        read_check("rst_mtime_lo", MB + 32'h00, 32'h0);
        irq_check("rst_irq", 32'h0);
        gpio_check("rst_gpio", 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // RAM write/read and region bounds
        write_word(RB + 32'h8, 32'hDEAD_BEEF);
        read_check("ram_rd", RB + 32'h8, 32'hDEAD_BEEF);
        read_check("ram_rd_lowbits", RB + 32'hB, 32'hDEAD_BEEF);
        read_check("ram_past_end", RB + 32'(4 * RW), 32'h0);
        read_check("ram_below_base", RB - 32'h4, 32'h0);
        write_word(RB + 32'(4 * RW - 4), 32'h1357_9BDF);
        read_check("ram_last_word", RB + 32'(4 * RW - 4), 32'h1357_9BDF);

        // mtime carry across the 32-bit boundary
        write_word(MB + 32'h04, 32'h0);
        write_word(MB + 32'h00, 32'hFFFF_FFFE);
        read_check("mt_lo_wr", MB + 32'h00, 32'hFFFF_FFFE);
        idle(1);
        read_check("mt_lo_ff", MB + 32'h00, 32'hFFFF_FFFF);
        read_check("mt_hi_0", MB + 32'h04, 32'h0);
        idle(1);
        read_check("mt_lo_wrap", MB + 32'h00, 32'h0);
        read_check("mt_hi_carry", MB + 32'h04, 32'h1);
        write_word(MB + 32'h00, 32'h1234_5678);
        read_check("mt_wr_vs_tick", MB + 32'h00, 32'h1234_5678);
        idle(1);
        read_check("mt_after_wr", MB + 32'h00, 32'h1234_5679);

        // Timer interrupt threshold
        write_word(MB + 32'h08, 32'd100);
        write_word(MB + 32'h0C, 32'd0);
        write_word(MB + 32'h04, 32'd0);
        write_word(MB + 32'h00, 32'd97);
        read_check("tm_start", MB + 32'h00, 32'd97);
        for (int v = 98; v <= 102; v++) begin
            idle(1);
            read_check($sformatf("tm_mtime_%0d", v), MB + 32'h00, 32'(v));
            sb_push($sformatf("tm_irq_%0d", v), {31'd0, v >= 101});
            #1;
            sb_pop({31'd0, external_interrupts[7]});
        end
        write_word(MB + 32'h0C, 32'd1);
        irq_check("tm_irq_hold", 32'h80);
        idle(1);
        irq_check("tm_irq_fall", 32'h0);

        // Software interrupt and MSIP storage width
        write_word(MB + 32'h14, 32'h1);
        irq_check("msip_set", 32'h08);
        read_check("msip_rd", MB + 32'h14, 32'h1);
        write_word(MB + 32'h14, 32'hFFFF_FFFE);
        irq_check("msip_clr", 32'h0);
        read_check("msip_rd0", MB + 32'h14, 32'h0);

        // Unmapped writes and counter saturation
        write_word(MB + 32'h10, 32'h5A5A_5A5A);
        gpio_check("gpio_set", 32'h5A5A_5A5A);
        read_check("bad_cnt_0", MB + 32'h18, 32'h0);
        for (int i = 0; i < 3; i++) write_word(UNM, 32'hAAAA_0000 + 32'(i));
        read_check("bad_cnt_3", MB + 32'h18, 32'd3);
        read_check("unm_ram_kept", RB + 32'h8, 32'hDEAD_BEEF);
        gpio_check("unm_gpio_kept", 32'h5A5A_5A5A);
        read_check("unm_rd_zero", UNM, 32'h0);
        idle(4);
        read_check("unm_rd_nocount", MB + 32'h18, 32'd3);
        write_word(MB + 32'h18, 32'h0000_1234);
        read_check("bad_cnt_ro", MB + 32'h18, 32'd3);
        write_word(MB + 32'h1C, 32'hFFFF_FFFF);
        read_check("reg_1c_zero", MB + 32'h1C, 32'h0);
        address        = UNM;
        write_data     = 32'h0;
        write_data_sig = 1'b1;
        repeat (65530) @(negedge clk);
        write_data_sig = 1'b0;
        read_check("bad_cnt_near", MB + 32'h18, 32'h0000_FFFD);
        write_word(UNM, 32'h1);
        write_word(UNM, 32'h2);
        read_check("bad_cnt_max", MB + 32'h18, 32'h0000_FFFF);
        write_word(UNM, 32'h3);
        write_word(UNM, 32'h4);
        read_check("bad_cnt_sat", MB + 32'h18, 32'h0000_FFFF);

        // Reset in the middle of activity
        write_word(MB + 32'h0C, 32'd0);
        idle(1);
        irq_check("pre_rst_irq", 32'h80);
        gpio_check("pre_rst_gpio", 32'h5A5A_5A5A);
        rst            = 1'b1;
        address        = MB + 32'h10;
        write_data     = 32'hFFFF_FFFF;
        write_data_sig = 1'b1;
        @(negedge clk);
        write_data_sig = 1'b0;
        gpio_check("rst_mid_gpio", 32'h0);
        irq_check("rst_mid_irq", 32'h0);
        read_check("rst_mid_mtime", MB + 32'h00, 32'h0);
        read_check("rst_mid_cmp_hi", MB + 32'h0C, 32'hFFFF_FFFF);
        read_check("rst_mid_badcnt", MB + 32'h18, 32'h0);
        rst = 1'b0;
        read_check("rst_ram_kept", RB + 32'h8, 32'hDEAD_BEEF);
        idle(2);
        read_check("post_rst_mtime", MB + 32'h00, 32'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
